// File: rtl/bcd_chain_counter_if.sv
// bcd_chain_counter_if: control/status bundle for bcd_chain_counter.
// Ports: clr, load, load_val, inc, dec in; q, tc, at_max, at_zero, ovf out;
// lap in, lap_q out only when BCD_CHAIN_LAP_EN is defined.
interface bcd_chain_counter_if #(
    parameter int NDIG = 4
);
    logic              clr;
    logic              load;
    logic [4*NDIG-1:0] load_val;
    logic              inc;
    logic              dec;
    logic [4*NDIG-1:0] q;
    logic              tc;
    logic              at_max;
    logic              at_zero;
    logic              ovf;
`ifdef BCD_CHAIN_LAP_EN
    logic              lap;
    logic [4*NDIG-1:0] lap_q;
`endif

    modport master (
`ifdef BCD_CHAIN_LAP_EN
        output lap,
        input  lap_q,
`endif
        output clr, load, load_val, inc, dec,
        input  q, tc, at_max, at_zero, ovf
    );

    modport slave (
`ifdef BCD_CHAIN_LAP_EN
        input  lap,
        output lap_q,
`endif
        input  clr, load, load_val, inc, dec,
        output q, tc, at_max, at_zero, ovf
    );
endinterface

// File: rtl/bcd_chain_counter.sv
// bcd_chain_counter: NDIG-digit BCD up/down counter, per-digit max MAX_VEC.
// Ports: clk, rst (sync, active-high), bus (slave): clr/load/load_val/inc/dec
// in; q/tc/at_max/at_zero/ovf out. Optional lap capture: BCD_CHAIN_LAP_EN.
module bcd_chain_counter #(
    parameter int              NDIG    = 4,
    parameter logic [4*NDIG-1:0] MAX_VEC = 16'h5959,
    parameter bit              WRAP    = 1'b1
) (
    input  logic clk,
    input  logic rst,
    bcd_chain_counter_if.slave bus
);

    localparam int W = 4 * NDIG;

    logic [W-1:0] q_q, q_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] up_v, dn_v, ld_v;
    logic         step_up, step_dn, ctrl;
    logic         at_max, at_zero, tc;

    assign step_up = bus.inc & ~bus.dec;
    assign step_dn = bus.dec & ~bus.inc;
    assign ctrl    = rst | bus.clr | bus.load;
    assign at_max  = (q_q == MAX_VEC);
    assign at_zero = (q_q == '0);
    assign tc      = ~ctrl & ((step_up & at_max) | (step_dn & at_zero));

    // Ripple carry/borrow: a digit moves only when all lower digits
    // sit at their roll-over value. Load nibbles clamp to the digit max.
    always_comb begin : chain
        logic [NDIG-1:0] cy;
        logic [NDIG-1:0] br;
        logic [3:0]      d;
        logic [3:0]      m;
        logic [3:0]      lv;
        cy    = '0;
        br    = '0;
        cy[0] = 1'b1;
        br[0] = 1'b1;
        d     = '0;
        m     = '0;
        lv    = '0;
        up_v  = q_q;
        dn_v  = q_q;
        ld_v  = '0;
        for (int i = 0; i < NDIG; i++) begin
            d  = q_q[4*i +: 4];
            m  = MAX_VEC[4*i +: 4];
            lv = bus.load_val[4*i +: 4];
            if (cy[i])
                up_v[4*i +: 4] = (d == m) ? 4'd0 : d + 4'd1;
            if (br[i])
                dn_v[4*i +: 4] = (d == 4'd0) ? m : d - 4'd1;
            if (i < NDIG - 1) begin
                cy[i+1] = cy[i] & (d == m);
                br[i+1] = br[i] & (d == 4'd0);
            end
            ld_v[4*i +: 4] = (lv > m) ? m : lv;
        end
    end

    always_comb begin
        q_d   = q_q;
        ovf_d = ovf_q | tc;
        if (bus.clr) begin
            q_d   = '0;
            ovf_d = 1'b0;
        end else if (bus.load) begin
            q_d   = ld_v;
            ovf_d = 1'b0;
        end else if (step_up) begin
            // Saturate mode holds at the terminal value.
            if (WRAP || !at_max)
                q_d = up_v;
        end else if (step_dn) begin
            if (WRAP || !at_zero)
                q_d = dn_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.tc      = tc;
    assign bus.at_max  = at_max;
    assign bus.at_zero = at_zero;
    assign bus.ovf     = ovf_q;

`ifdef BCD_CHAIN_LAP_EN
    logic [W-1:0] lap_q_q;

    // Captures the pre-edge (displayed) value; load does not touch it.
    always_ff @(posedge clk) begin
        if (rst || bus.clr)
            lap_q_q <= '0;
        else if (bus.lap)
            lap_q_q <= q_q;
    end

    assign bus.lap_q = lap_q_q;
`endif

endmodule

// File: tb/tb_bcd_chain_counter.sv
// tb_bcd_chain_counter: directed table-driven bench for bcd_chain_counter.
// Covers wrap (A) and saturate (B) builds; lap checks with BCD_CHAIN_LAP_EN.
module tb_bcd_chain_counter;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_tot = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    bcd_chain_counter_if #(.NDIG(4)) ba ();
    bcd_chain_counter_if #(.NDIG(4)) bb ();

    bcd_chain_counter #(.NDIG(4), .MAX_VEC(16'h5959), .WRAP(1'b1)) dut_a (
        .clk(clk),
        .rst(rst_a),
        .bus(ba)
    );

    bcd_chain_counter #(.NDIG(4), .MAX_VEC(16'h5959), .WRAP(1'b0)) dut_b (
        .clk(clk),
        .rst(rst_b),
        .bus(bb)
    );

    typedef struct packed {
        logic        rst;
        logic        clr;
        logic        load;
        logic [15:0] lv;
        logic        inc;
        logic        dec;
        logic        e_tc;
        logic [15:0] e_q;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic idle_a();
        rst_a = 0; ba.clr = 0; ba.load = 0; ba.load_val = '0;
        ba.inc = 0; ba.dec = 0;
`ifdef BCD_CHAIN_LAP_EN
        ba.lap = 0;
`endif
    endtask

    task automatic idle_b();
        rst_b = 0; bb.clr = 0; bb.load = 0; bb.load_val = '0;
        bb.inc = 0; bb.dec = 0;
`ifdef BCD_CHAIN_LAP_EN
        bb.lap = 0;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic r, logic c, logic l, logic [15:0] v,
                                logic i, logic d, logic t,
                                logic [15:0] q, logic o);
        vec_t x;
        x.rst = r; x.clr = c; x.load = l; x.lv = v;
        x.inc = i; x.dec = d; x.e_tc = t; x.e_q = q; x.e_ovf = o;
        return x;
    endfunction

    initial begin
        vecs[0]  = mk(1, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0);
        vecs[1]  = mk(0, 0, 1, 16'h5958, 0, 0, 0, 16'h5958, 0);
        vecs[2]  = mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h5959, 0);
        vecs[3]  = mk(0, 0, 0, 16'h0000, 1, 0, 1, 16'h0000, 1);
        vecs[4]  = mk(0, 0, 0, 16'h0000, 0, 1, 1, 16'h5959, 1);
        vecs[5]  = mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h5958, 1);
        vecs[6]  = mk(0, 0, 1, 16'hA7F3, 0, 0, 0, 16'h5753, 0);
        vecs[7]  = mk(0, 0, 0, 16'h0000, 1, 1, 0, 16'h5753, 0);
        vecs[8]  = mk(0, 0, 1, 16'h0959, 0, 0, 0, 16'h0959, 0);
        vecs[9]  = mk(0, 1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0);
        vecs[10] = mk(0, 0, 1, 16'h0899, 0, 0, 0, 16'h0859, 0);
        vecs[11] = mk(0, 0, 0, 16'h0000, 1, 0, 0, 16'h0900, 0);
        vecs[12] = mk(0, 0, 0, 16'h0000, 0, 1, 0, 16'h0859, 0);
        vecs[13] = mk(0, 0, 1, 16'h1111, 1, 0, 0, 16'h1111, 0);
        vecs[14] = mk(1, 0, 1, 16'h2222, 1, 0, 0, 16'h0000, 0);
        vecs[15] = mk(0, 1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0);

        idle_a();
        idle_b();
        rst_a = 1;
        rst_b = 1;
        tick();
        idle_a();
        idle_b();
        #1;
        chk("rst_q", ba.q, 16'h0000);
        chk("rst_ovf", ba.ovf, 0);
        chk("rst_at_zero", ba.at_zero, 1);
        chk("rst_at_max", ba.at_max, 0);
        chk("rst_tc", ba.tc, 0);

        for (int k = 0; k < 16; k++) begin
            rst_a       = vecs[k].rst;
            ba.clr      = vecs[k].clr;
            ba.load     = vecs[k].load;
            ba.load_val = vecs[k].lv;
            ba.inc      = vecs[k].inc;
            ba.dec      = vecs[k].dec;
            #1;
            chk($sformatf("v%0d_tc", k), ba.tc, vecs[k].e_tc);
            tick();
            chk($sformatf("v%0d_q", k), ba.q, vecs[k].e_q);
            chk($sformatf("v%0d_ovf", k), ba.ovf, vecs[k].e_ovf);
        end

        // Full 59:59 sweep from reset, then wrap.
        idle_a();
        rst_a = 1;
        tick();
        rst_a = 0;
        ba.inc = 1;
        repeat (3599) @(posedge clk);
        #1;
        ba.inc = 0;
        #1;
        chk("sweep_q", ba.q, 16'h5959);
        chk("sweep_at_max", ba.at_max, 1);
        chk("sweep_tc_idle", ba.tc, 0);
        chk("sweep_ovf", ba.ovf, 0);
        ba.inc = 1;
        #1;
        chk("sweep_tc", ba.tc, 1);
        tick();
        ba.inc = 0;
        chk("sweep_wrap_q", ba.q, 16'h0000);
        chk("sweep_wrap_ovf", ba.ovf, 1);

        // Saturating instance.
        bb.load = 1;
        bb.load_val = 16'h5958;
        tick();
        bb.load = 0;
        for (int k = 0; k < 3; k++) begin
            bb.inc = 1;
            #1;
            chk($sformatf("sat%0d_tc", k), bb.tc, (k == 0) ? 0 : 1);
            tick();
            chk($sformatf("sat%0d_q", k), bb.q, 16'h5959);
            chk($sformatf("sat%0d_ovf", k), bb.ovf, (k == 0) ? 0 : 1);
        end
        idle_b();
        bb.clr = 1;
        tick();
        bb.clr = 0;
        bb.dec = 1;
        #1;
        chk("satdn_tc", bb.tc, 1);
        tick();
        bb.dec = 0;
        chk("satdn_q", bb.q, 16'h0000);
        chk("satdn_ovf", bb.ovf, 1);

`ifdef BCD_CHAIN_LAP_EN
        idle_a();
        ba.load = 1;
        ba.load_val = 16'h1234;
        tick();
        ba.load = 0;
        ba.lap = 1;
        ba.inc = 1;
        tick();
        idle_a();
        chk("lap_q", ba.lap_q, 16'h1234);
        chk("lap_cnt", ba.q, 16'h1235);
        ba.load = 1;
        ba.load_val = 16'h0001;
        tick();
        ba.load = 0;
        chk("lap_keep", ba.lap_q, 16'h1234);
        ba.clr = 1;
        tick();
        ba.clr = 0;
        chk("lap_clr", ba.lap_q, 16'h0000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/bcd_chain_counter.md
Name: bcd_chain_counter

Overview:
Parametrised cascade of NDIG BCD digit counters with a programmable per-digit maximum, so one instance covers a plain decimal counter or an mm:ss / ss:cc stopwatch field. Supports up/down counting, parallel load, clear, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. It sits between the tick generator and the display/keyboard-control logic of the stopwatch datapath and replaces hand-chained single-digit counters.

Parameters:
NDIG, 4, number of BCD digits; legal range 1..8; digit 0 is least significant.
MAX_VEC, 16'h5959, packed per-digit maximum, 4 bits per digit, digit i at [4i+3:4i]; each nibble must be 1..9. Default gives a 59:59 field.
WRAP, 1, 1 = wrap at the terminal value; 0 = saturate and hold.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clr  in  1  synchronous clear to zero; same effect as rst on q and ovf
load  in  1  synchronous parallel load of load_val
load_val  in  4*NDIG  BCD value to load
inc  in  1  count-up enable, one step per cycle
dec  in  1  count-down enable, one step per cycle
q  out  4*NDIG  current count, packed BCD
tc  out  1  terminal-count pulse, combinational
at_max  out  1  q equals MAX_VEC, combinational
at_zero  out  1  q equals 0, combinational
ovf  out  1  sticky flag: a terminal count has occurred since the last rst/clr/load

Behaviour:
- Reset is synchronous and active-high on rst, clocked on clk. After reset, q=0 and ovf=0. tc, at_max and at_zero follow from q and the inputs: tc=0 unless dec=1, at_zero=1, at_max=0.
- Priority per rising edge: rst > clr > load > (inc XOR dec). If inc and dec are both 1 in the same cycle, q holds and tc=0.
- load: each digit takes load_val[4i+3:4i]. Any nibble greater than its MAX_VEC nibble, including non-BCD codes A–F, is clamped to that maximum. load clears ovf. Latency is 1 cycle.
- Up step (inc only): digit 0 increments. Digit i at its maximum rolls to 0 and carries into digit i+1. Digit i+1 increments only when all lower digits are at their maximum.
- Down step (dec only): digit 0 decrements. Digit i at 0 reloads to its maximum and borrows from digit i+1.
- Terminal up: at_max=1 and inc=1, with dec=0 and no higher-priority control active.
  - tc=1 in that same cycle.
  - WRAP=1: q becomes 0 on the next edge.
  - WRAP=0: q holds at MAX_VEC.
- Terminal down: at_zero=1 and dec=1.
  - tc=1 in that same cycle.
  - WRAP=1: q becomes MAX_VEC on the next edge.
  - WRAP=0: q holds at 0.
- tc is forced to 0 whenever rst, clr or load is 1.
- tc remains asserted on each qualifying cycle even in saturate mode, so cascaded counters see every attempted overflow.
- ovf is set on the edge following any tc=1 cycle. It is cleared only by rst, clr or load.
- q never holds a digit above its maximum. The register only changes by step, load (clamped) or clear.
- rst or clr mid-count discards any pending step. A tc computed in that cycle is suppressed.
- Cascading: tc of one instance drives inc (or dec) of the next; the combined chain counts in one cycle per step.

Optional Feature:
Macro BCD_CHAIN_LAP_EN.
- Defined: adds input lap (1 bit) and output lap_q (4*NDIG bits).
  - On a rising edge with lap=1, lap_q captures the q value present before that edge's update, i.e. the displayed value.
  - lap has lower priority than rst/clr; load does not affect lap_q.
  - lap_q resets to 0 on rst and clr.
- Undefined: lap and lap_q are absent and no capture register is built.

Test Plan:
- Default params; rst, then 3599 cycles of inc=1 -> q=16'h5959, at_max=1, tc=0; next inc cycle -> tc=1, then q=16'h0000, ovf=1.
- q=16'h0000, dec=1 for one cycle -> tc=1; next edge q=16'h5959, ovf=1; one more dec -> q=16'h5958, tc=0.
- WRAP=0; load 16'h5958, inc for 3 cycles -> q=5959, 5959, 5959 with tc=0,1,1; ovf=1 from cycle 3 onward.
- load_val=16'hA7F3 -> q=16'h5753 (digit 3 clamped from A to 5, digit 1 clamped from F to 5), ovf=0; inc and dec both 1 -> q unchanged, tc=0.
- q=16'h0959, inc=1 and clr=1 same cycle -> q=0, tc=0, ovf=0; rst mid-run with load=1 -> q=0.
- BCD_CHAIN_LAP_EN defined: q=16'h1234, lap=1 with inc=1 -> lap_q=16'h1234 and q=16'h1235; clr -> lap_q=0.
